// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NUM_REQ requesters.
// A stalled slave is timed out in WAIT; the late response is then drained without an ack.
//   state | meaning
//   IDLE  | arbitrate pending requests, latch winner's command
//   ISSUE | one-cycle transfer pulse to the master
//   WAIT  | hold command, wait for ready or timeout
//   DRAIN | requester already released, swallow the late ready
module apb_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [31:0]            req_rdata,
  output logic                   busy,
  output logic                   transfer,
  output logic                   write,
  output logic [31:0]            addr,
  output logic [31:0]            wdata,
  input  logic                   ready,
  input  logic [31:0]            rdata
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] TIMER_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d, last_q, last_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               write_q, write_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] ack_q, ack_d, err_q, err_d;

  logic               found;
  logic [IDX_W-1:0]   pick, cand;
  logic [31:0]        sel_addr, sel_wdata;

  // Scan starts one past the last completed grant, so the previous winner goes last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) begin
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          write_d = req_write[pick];
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // ready takes precedence over a timeout expiring in the same cycle
        if (ready) begin
          if (!write_q) rdata_d = rdata;
          ack_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = IDLE;
        end else if (TIMEOUT != 0 && timer_q == TIMER_LAST) begin
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          last_d         = grant_q;
          state_d        = DRAIN;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      timer_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign transfer  = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign write     = write_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign req_rdata = rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-level reference model compared every cycle,
// directed scenarios with hand-computed timings, then randomized requesters and slave latency.
module tb_apb_req_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b0;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*32-1:0] req_addr = '0, req_wdata = '0;
  logic [N-1:0]    req_ack, req_err;
  logic [31:0]     req_rdata, addr, wdata;
  logic            busy, transfer, write;
  logic            ready = 1'b0;
  logic [31:0]     rdata = '0;

  apb_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
    .busy(busy), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata)
  );

  always #5 PCLK = ~PCLK;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int tx_q[$];
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction described by how many edges have passed since its grant.
  bit          m_busy = 0, m_drain = 0, m_write = 0;
  int          m_age = 0, m_g = 0, m_last = N - 1;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [N-1:0] m_ack = '0, m_err = '0;

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_busy = 0; m_drain = 0; m_write = 0; m_age = 0; m_g = 0; m_last = N - 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_ack = '0; m_err = '0;
    end else begin
      m_ack = '0;
      m_err = '0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (!m_busy && req_valid[j]) begin
            m_busy = 1; m_age = 0; m_g = j;
            m_write = req_write[j];
            m_addr  = req_addr[32*j +: 32];
            m_wdata = req_wdata[32*j +: 32];
          end
        end
      end else if (m_drain) begin
        if (ready) begin m_busy = 0; m_drain = 0; end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (ready) begin
        m_ack[m_g] = 1'b1;
        if (!m_write) m_rdata = rdata;
        m_last = m_g; m_busy = 0;
      end else if (m_age == TO) begin
        m_ack[m_g] = 1'b1; m_err[m_g] = 1'b1;
        m_last = m_g; m_drain = 1;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge PCLK) begin
    chk("busy", busy, m_busy);
    chk("transfer", transfer, m_busy && !m_drain && m_age == 0);
    chk("write", write, m_write);
    chk("addr", addr, m_addr);
    chk("wdata", wdata, m_wdata);
    chk("req_ack", req_ack, m_ack);
    chk("req_err", req_err, m_err);
    chk("req_rdata", req_rdata, m_rdata);
    if (transfer) tx_q.push_back(cyc);
  end

  // Slave: answers each transfer after a programmed number of low-ready WAIT cycles.
  bit [31:0] mem [bit [31:0]];
  bit        rand_lat = 0;
  int        slv_lat = 0;
  bit        s_write;
  bit [31:0] s_addr, s_wdata;
  initial begin : slave
    bit pend;
    int cnt;
    pend = 0; cnt = 0;
    forever begin
      @(negedge PCLK);
      ready = 1'b0;
      if (PRESET) pend = 0;
      else if (pend) begin
        if (cnt == 0) begin
          ready = 1'b1; pend = 0;
          if (s_write) begin mem[s_addr] = s_wdata; rdata = $urandom; end
          else rdata = mem.exists(s_addr) ? mem[s_addr] : (32'hDEAD_0000 ^ s_addr);
        end else cnt--;
      end else if (transfer) begin
        pend = 1;
        cnt = rand_lat ? int'($urandom_range(0, 12)) : slv_lat;
        s_addr = addr; s_write = write; s_wdata = wdata;
      end
    end
  end

  task automatic set_req(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    req_write[i] = w;
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = d;
  endtask

  task automatic wait_ack(input string nm, output int idx, output int t);
    idx = -1; t = -1;
    for (int n = 0; n < 200; n++) begin
      @(negedge PCLK);
      if (|req_ack) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
        t = cyc;
        return;
      end
    end
    vectors++; miscompares++;
    $display("FAIL %s: no req_ack within 200 cycles, expected one", nm);
  endtask

  task automatic wait_tx(input string nm);
    for (int n = 0; n < 200; n++) begin
      @(negedge PCLK);
      if (transfer) return;
    end
    vectors++; miscompares++;
    $display("FAIL %s: no transfer within 200 cycles, expected one", nm);
  endtask

  initial begin
    int idx, t;
    #1 PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("reset_ctl", {busy, transfer, write, req_ack, req_err}, 0);
    chk("reset_addr", addr, 0);
    chk("reset_rdata", req_rdata, 0);

    // Contention from reset: grants alternate 0,1,0,1 with 3-cycle spacing at zero slave latency
    slv_lat = 0;
    set_req(0, 1, 32'h1000_0004, 32'hA0A0_0001);
    set_req(1, 1, 32'h1000_1000, 32'hB0B0_0002);
    req_valid = 3'b011;
    PRESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_ack("cont_ack", idx, t);
      if (k == 3) req_valid = '0;
      chk("cont_order", idx, k % 2);
    end
    chk("cont_spacing", tx_q.size() > 1 ? tx_q[1] - tx_q[0] : 0, 3);
    repeat (3) @(negedge PCLK);

    // Single write, two-cycle slave latency
    tx_q.delete();
    slv_lat = 2;
    set_req(0, 1, 32'h1000_0000, 32'h1);
    req_valid[0] = 1'b1;
    wait_ack("t1_ack", idx, t);
    req_valid[0] = 1'b0;
    chk("t1_idx", idx, 0);
    chk("t1_err", req_err, 0);
    chk("t1_lat", t - (tx_q.size() > 0 ? tx_q[0] : 0), 4);
    chk("t1_ntx", tx_q.size(), 1);
    repeat (2) @(negedge PCLK);

    // Read-back by requester 1
    tx_q.delete();
    slv_lat = 1;
    set_req(1, 0, 32'h1000_0000, 32'h0);
    req_valid[1] = 1'b1;
    wait_ack("t2_ack", idx, t);
    req_valid[1] = 1'b0;
    chk("t2_idx", idx, 1);
    chk("t2_rdata", req_rdata, 32'h1);
    chk("t2_lat", t - (tx_q.size() > 0 ? tx_q[0] : 0), 3);
    repeat (2) @(negedge PCLK);

    // Timeout: slave stalls 20 cycles; req1 waits behind the drain
    tx_q.delete();
    slv_lat = 20;
    set_req(0, 1, 32'h1000_0008, 32'h55);
    req_valid[0] = 1'b1;
    wait_tx("t4_tx");
    @(negedge PCLK);
    slv_lat = 0;
    set_req(1, 0, 32'h1000_0000, 32'h0);
    req_valid[1] = 1'b1;
    wait_ack("t4_ack0", idx, t);
    req_valid[0] = 1'b0;
    chk("t4_idx0", idx, 0);
    chk("t4_err", req_err, 3'b001);
    chk("t4_lat", t - (tx_q.size() > 0 ? tx_q[0] : 0), 9);
    wait_ack("t4_ack1", idx, t);
    req_valid[1] = 1'b0;
    chk("t4_idx1", idx, 1);
    chk("t4_gap", tx_q.size() > 1 ? tx_q[1] - tx_q[0] : 0, 23);
    repeat (2) @(negedge PCLK);

    // Ready in the exact expiry cycle: normal ack, back to IDLE
    tx_q.delete();
    slv_lat = 7;
    set_req(0, 1, 32'h1000_000C, 32'h77);
    req_valid[0] = 1'b1;
    wait_ack("t5_ack", idx, t);
    req_valid[0] = 1'b0;
    chk("t5_idx", idx, 0);
    chk("t5_err", req_err, 0);
    chk("t5_busy", busy, 0);
    chk("t5_lat", t - (tx_q.size() > 0 ? tx_q[0] : 0), 9);
    repeat (2) @(negedge PCLK);

    // Asynchronous reset in WAIT; afterwards requester 0 wins first
    slv_lat = 10;
    set_req(1, 0, 32'h1000_0004, 32'h0);
    req_valid[1] = 1'b1;
    wait_tx("t6_tx");
    repeat (2) @(negedge PCLK);
    #2 PRESET = 1'b1;
    #1;
    chk("t6_rst_ctl", {busy, transfer, write, req_ack, req_err}, 0);
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_rdata", req_rdata, 0);
    set_req(0, 1, 32'h1000_0010, 32'h99);
    req_valid = 3'b011;
    slv_lat = 1;
    @(negedge PCLK);
    PRESET = 1'b0;
    wait_ack("t6_ack0", idx, t);
    req_valid[0] = 1'b0;
    chk("t6_first", idx, 0);
    wait_ack("t6_ack1", idx, t);
    req_valid[1] = 1'b0;
    chk("t6_second", idx, 1);
    repeat (2) @(negedge PCLK);

    // Randomized requesters and slave latency, checked by the per-cycle model
    rand_lat = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge PCLK);
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] || !req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            set_req(i, 1'($urandom_range(0, 1)), 32'h1000_0000 | (32'($urandom_range(0, 7)) << 2), $urandom);
            req_valid[i] = 1'b1;
          end else req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    repeat (40) @(negedge PCLK);
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
